// File: rtl/lmc1992_pkg.sv
// Shared constants for the STE Microwire master and LMC1992 register model.
// Command codes, clamps, reset values, register offsets and the shifter state type.
package lmc1992_pkg;

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned VAL_W   = 6;
    localparam int unsigned RXCNT_W = 5;

    localparam logic [CMD_W-1:0] CMD_MIX    = 3'b000;
    localparam logic [CMD_W-1:0] CMD_BASS   = 3'b001;
    localparam logic [CMD_W-1:0] CMD_TREBLE = 3'b010;
    localparam logic [CMD_W-1:0] CMD_MASTER = 3'b011;
    localparam logic [CMD_W-1:0] CMD_RIGHT  = 3'b100;
    localparam logic [CMD_W-1:0] CMD_LEFT   = 3'b101;

    localparam logic [5:0] MASTER_MAX = 6'd40;
    localparam logic [4:0] LR_MAX     = 5'd20;
    localparam logic [3:0] TONE_MAX   = 4'd12;

    localparam logic [5:0] MASTER_RST = 6'd40;
    localparam logic [4:0] LEFT_RST   = 5'd20;
    localparam logic [4:0] RIGHT_RST  = 5'd20;
    localparam logic [3:0] BASS_RST   = 4'd6;
    localparam logic [3:0] TREBLE_RST = 4'd6;
    localparam logic [1:0] MIX_RST    = 2'd1;
    localparam logic [1:0] MIX_RSVD   = 2'd3;

    localparam logic [4:0] REG_DATA   = 5'h11;
    localparam logic [4:0] REG_MASK   = 5'h12;
    localparam logic [1:0] FRAME_ADDR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } mw_state_e;

    function automatic logic [15:0] rotl16(input logic [15:0] x);
        return {x[14:0], x[15]};
    endfunction

endpackage

// File: rtl/ste_microwire_if.sv
// CPU-side access bus of the STE sound register page as seen by the Microwire block.
interface ste_microwire_if;
    logic [15:0] din;
    logic [4:0]  addr;
    logic        sel;
    logic        uds;
    logic        lds;
    logic        rw;
    logic [15:0] dout;

    modport master (output din, addr, sel, uds, lds, rw, input dout);
    modport slave  (input din, addr, sel, uds, lds, rw, output dout);
endinterface

// File: rtl/lmc1992_regs.sv
// LMC1992 setting registers: decodes a received frame, clamps the value and
// holds the mixer settings; cfg_strobe marks every accepted write.
module lmc1992_regs
    import lmc1992_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               cfg_strobe_o,
    output logic [5:0]         master_vol_o,
    output logic [4:0]         left_vol_o,
    output logic [4:0]         right_vol_o,
    output logic [3:0]         bass_o,
    output logic [3:0]         treble_o,
    output logic [1:0]         mix_o
);

    logic [CMD_W-1:0] cmd;
    logic [VAL_W-1:0] val;
    logic             accept;

    logic       strobe_q, strobe_d;
    logic [5:0] master_q, master_d;
    logic [4:0] left_q, left_d, right_q, right_d;
    logic [3:0] bass_q, bass_d, treble_q, treble_d;
    logic [1:0] mix_q, mix_d;

    assign cmd    = frame_i[8:6];
    assign val    = frame_i[5:0];
    assign accept = frame_valid_i && (frame_i[10:9] == FRAME_ADDR);

    always_comb begin
        strobe_d = 1'b0;
        master_d = master_q;
        left_d   = left_q;
        right_d  = right_q;
        bass_d   = bass_q;
        treble_d = treble_q;
        mix_d    = mix_q;
        if (accept) begin
            unique case (cmd)
                CMD_MIX: begin
                    // mix value 3 is reserved and leaves the setting untouched
                    if (val[1:0] != MIX_RSVD) begin
                        mix_d    = val[1:0];
                        strobe_d = 1'b1;
                    end
                end
                CMD_BASS: begin
                    bass_d   = (val[3:0] > TONE_MAX) ? TONE_MAX : val[3:0];
                    strobe_d = 1'b1;
                end
                CMD_TREBLE: begin
                    treble_d = (val[3:0] > TONE_MAX) ? TONE_MAX : val[3:0];
                    strobe_d = 1'b1;
                end
                CMD_MASTER: begin
                    master_d = (val > MASTER_MAX) ? MASTER_MAX : val;
                    strobe_d = 1'b1;
                end
                CMD_RIGHT: begin
                    right_d  = (val[4:0] > LR_MAX) ? LR_MAX : val[4:0];
                    strobe_d = 1'b1;
                end
                CMD_LEFT: begin
                    left_d   = (val[4:0] > LR_MAX) ? LR_MAX : val[4:0];
                    strobe_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
            master_q <= MASTER_RST;
            left_q   <= LEFT_RST;
            right_q  <= RIGHT_RST;
            bass_q   <= BASS_RST;
            treble_q <= TREBLE_RST;
            mix_q    <= MIX_RST;
        end else begin
            strobe_q <= strobe_d;
            master_q <= master_d;
            left_q   <= left_d;
            right_q  <= right_d;
            bass_q   <= bass_d;
            treble_q <= treble_d;
            mix_q    <= mix_d;
        end
    end

    assign cfg_strobe_o = strobe_q;
    assign master_vol_o = master_q;
    assign left_vol_o   = left_q;
    assign right_vol_o  = right_q;
    assign bass_o       = bass_q;
    assign treble_o     = treble_q;
    assign mix_o        = mix_q;

endmodule

// File: rtl/ste_microwire.sv
// STE Microwire master: CPU data/mask registers, 16-bit rotating shifter and
// frame capture feeding the LMC1992 register model.
module ste_microwire
    import lmc1992_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 8,
    parameter int unsigned NBITS     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_8_en,
    ste_microwire_if.slave   bus,
    output logic             busy,
    output logic             cfg_strobe,
    output logic [5:0]       master_vol,
    output logic [4:0]       left_vol,
    output logic [4:0]       right_vol,
    output logic [3:0]       bass,
    output logic [3:0]       treble,
    output logic [1:0]       mix
);

    localparam int unsigned TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

    mw_state_e            state_q, state_d;
    logic [15:0]          data_q, data_d;
    logic [15:0]          mask_q, mask_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [RXCNT_W-1:0]   rxcnt_q, rxcnt_d;
    logic                 busy_q, busy_d;
    logic [15:0]          dout_q, dout_d;
    logic                 wr_c;
    logic                 frame_valid_c;

    assign wr_c = bus.sel && !bus.rw && clk_8_en;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        mask_d        = mask_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        rx_d          = rx_q;
        rxcnt_d       = rxcnt_q;
        frame_valid_c = 1'b0;
        dout_d        = 16'h0000;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_c && bus.addr == REG_MASK) begin
                    if (bus.uds) mask_d[15:8] = bus.din[15:8];
                    if (bus.lds) mask_d[7:0]  = bus.din[7:0];
                end else if (wr_c && bus.addr == REG_DATA) begin
                    if (bus.uds) data_d[15:8] = bus.din[15:8];
                    if (bus.lds) data_d[7:0]  = bus.din[7:0];
                    tick_d  = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    rxcnt_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_8_en) begin
                    if (tick_q == TICK_W'(BIT_TICKS - 1)) begin
                        tick_d = '0;
                        // sample before rotating: the bit leaving [15] is the one sent
                        if (mask_q[15]) begin
                            rx_d = {rx_q[FRAME_W-2:0], data_q[15]};
                            if (rxcnt_q != {RXCNT_W{1'b1}}) rxcnt_d = rxcnt_q + RXCNT_W'(1);
                        end
                        data_d = rotl16(data_q);
                        mask_d = rotl16(mask_q);
                        if (bit_q == BIT_W'(NBITS - 1)) begin
                            bit_d   = '0;
                            state_d = ST_LATCH;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                frame_valid_c = (rxcnt_q >= RXCNT_W'(FRAME_W));
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        if (bus.sel && bus.rw) begin
            if (bus.addr == REG_DATA)      dout_d = data_d;
            else if (bus.addr == REG_MASK) dout_d = mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            rxcnt_q <= '0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rxcnt_q <= rxcnt_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.dout = dout_q;
    assign busy     = busy_q;

    lmc1992_regs u_regs (
        .clk           (clk),
        .reset         (reset),
        .frame_valid_i (frame_valid_c),
        .frame_i       (rx_q),
        .cfg_strobe_o  (cfg_strobe),
        .master_vol_o  (master_vol),
        .left_vol_o    (left_vol),
        .right_vol_o   (right_vol),
        .bass_o        (bass),
        .treble_o      (treble),
        .mix_o         (mix)
    );

endmodule

// File: doc/ste_microwire.md
Name: ste_microwire

Overview:
STE Microwire master plus LMC1992 register model, which configures the audio mixer, volume and tone path downstream of the YM2149 and STE DMA sound.
- Provides the CPU-visible Microwire data register (word offset addr[5:1]=5'h11) and mask register (addr[5:1]=5'h12) in the STE sound register page.
- Serialises a 16-bit transfer over 16 µs.
- Decodes the LMC1992 frame and holds the resulting volume, tone and mix settings as outputs for the mixer.

Parameters:
BIT_TICKS, 8, clk_8_en pulses per Microwire bit period (8 → 1 µs per bit at 8 MHz).
NBITS, 16, bit periods per transfer.

Ports:
clk  in  1  system clock, 32 MHz
reset  in  1  synchronous, active-high reset
clk_8_en  in  1  8 MHz clock enable
din  in  16  CPU write data
addr  in  5  CPU word address bits [5:1]
sel  in  1  Microwire/STE sound page select
uds  in  1  upper byte strobe
lds  in  1  lower byte strobe
rw  in  1  1=read, 0=write
dout  out  16  read data, 16'h0000 when not selected
busy  out  1  transfer in progress
cfg_strobe  out  1  one-clk pulse when a decoded setting is updated
master_vol  out  6  0..40, units of -2 dB attenuation complement
left_vol  out  5  0..20
right_vol  out  5  0..20
bass  out  4  0..12, 6 = flat
treble  out  4  0..12, 6 = flat
mix  out  2  0=-12dB YM, 1=YM+DMA, 2=DMA only

Behaviour:
- Reset values: data=0, mask=0, busy=0, cfg_strobe=0, master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mix=1, dout=0. Reset mid-transfer aborts it and discards the partial frame.
- Register writes are sampled only on clk_8_en cycles with sel & ~rw. uds writes [15:8] and lds writes [7:0] of the addressed register.
- Mask writes are accepted only while idle.
- A data write while idle loads data and starts a transfer in the same clock: busy=1, bit counter=0, tick counter=0, rx_count=0.
- Writes to either register while busy=1 are ignored. This also suppresses the repeat cycles of the starting access.
- Reads return the live register value on dout when sel & rw and addr matches; otherwise dout=0. Reads have no side effects.
- Shifter states: IDLE → SHIFT → LATCH → IDLE.
  - SHIFT: at the last tick of each bit period (tick counter = BIT_TICKS-1 on a clk_8_en), sample the current mask[15] and data[15] first.
    - If mask[15]=1: shift data[15] into the 11-bit rx register (MSB first) and increment rx_count, saturating at 31.
    - Then rotate both data and mask left by 1 (bit 15 → bit 0).
  - After NBITS bit periods (128 clk_8_en pulses), both registers equal their written values again; enter LATCH.
  - LATCH lasts 1 clk. If rx_count≥11 and rx[10:9]=2'b10, decode cmd=rx[8:6] and val=rx[5:0], then return to IDLE (busy=0) the next clk.
- Decode rules:
  - cmd 000: mix=val[1:0]. Value 3 is reserved; ignore it with no strobe.
  - cmd 001: bass=min(val[3:0],12).
  - cmd 010: treble=min(val[3:0],12).
  - cmd 011: master_vol=min(val,40).
  - cmd 100: right_vol=min(val[4:0],20).
  - cmd 101: left_vol=min(val[4:0],20).
  - cmd 11x: ignored.
- cfg_strobe pulses for one clk in the LATCH cycle only when an output is written, even if the value is unchanged.
- rx_count<11 or a wrong address field: the frame is discarded with no strobe. If more than 11 bits are received, the last 11 bits are used.

Decomposition:
- Shared package lmc1992_pkg:
  - command codes CMD_MIX/BASS/TREBLE/MASTER/RIGHT/LEFT
  - max values 40/20/12
  - reset values (40, 20, 20, 6, 6, 1)
  - register word offsets 5'h11 and 5'h12
  - frame address field 2'b10
- One sub-module, lmc1992_regs: takes an 11-bit frame and a valid pulse, and owns the clamping and the output registers. ste_microwire owns the CPU interface and shifter.

Test Plan:
1. Write mask 16'h07FF, then data 16'h054A → busy high for 128 clk_8_en; left_vol=10 with one cfg_strobe; all other outputs unchanged.
2. After one bit period of transfer 1 → mask reads 16'h0FFE and data reads 16'h0A94. After completion → reads return 16'h07FF and 16'h054A.
3. Mask 16'h07FF, data 16'h04FF (master 63) → master_vol=40 (clamped) with cfg_strobe. Data 16'h04D4 → master_vol=20.
4. Mask 16'h00FF (8 bits), any data → transfer completes, no cfg_strobe, outputs hold reset values. Frame with address 2'b01 (data 16'h02D4, mask 16'h07FF) → discarded.
5. Write data 16'h054A, then write data 16'h0545 and mask 16'h0000 mid-transfer → both ignored; left_vol=10 at end.
6. Assert reset at bit period 8 of a master-volume transfer → busy=0 next clk; master_vol stays 40; no cfg_strobe; a following transfer works normally.
